// File: rtl/fifo_push_arbiter_if.sv
// Push-side bundle between NREQ producers, the arbiter and its FIFO.
// Producers and the FIFO pop copy drive the slave inputs; the arbiter drives the rest.
interface fifo_push_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int NREQ  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NREQ-1:0]       req_i;
  logic [NREQ*WIDTH-1:0] data_i;
  logic [NREQ-1:0]       gnt_o;
  logic                  pop_i;
  logic                  push_o;
  logic [WIDTH-1:0]      data_o;
  logic [CW-1:0]         count_o;
  logic                  full_o;
  logic                  busy_o;

  modport master (
    output req_i, data_i, pop_i,
    input  gnt_o, push_o, data_o, count_o, full_o, busy_o
  );

  modport slave (
    input  req_i, data_i, pop_i,
    output gnt_o, push_o, data_o, count_o, full_o, busy_o
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter sharing one FIFO push port between NREQ producers, with occupancy tracking.
// Define FIFO_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module fifo_push_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int NREQ  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  fifo_push_arbiter_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, STALL} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_count;
  logic             r_push;
  logic [WIDTH-1:0] r_data;

  logic             w_room;
  logic             w_found;
  logic             w_grant;
  logic             w_pop_ok;
  logic [PW-1:0]    w_sel;
  logic [WIDTH-1:0] w_word;

`ifndef FIFO_ARB_FIXED_PRIO_EN
  logic [PW-1:0]    r_ptr;
`endif

  // A pop in the same cycle never creates room; only the committed count matters.
  assign w_room   = (r_count < CW'(DEPTH));
  assign w_pop_ok = bus.pop_i && (r_count != '0);

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
`ifdef FIFO_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && bus.req_i[i]) begin
        w_found = 1'b1;
        w_sel   = PW'(i);
      end
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      logic [PW:0] idx;
      idx = {1'b0, r_ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NREQ)) idx = idx - (PW+1)'(NREQ);
      if (!w_found && bus.req_i[idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = idx[PW-1:0];
      end
    end
`endif
  end

  // Gated by rst_i so the combinational grant drops together with the async reset.
  assign w_grant   = w_found && w_room && !rst_i;
  assign w_word    = bus.data_i[w_sel*WIDTH +: WIDTH];
  assign bus.gnt_o = w_grant ? (NREQ'(1) << w_sel) : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_push  <= 1'b0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_push <= w_grant;
      if (w_grant) r_data <= w_word;
      if (w_grant && !w_pop_ok)      r_count <= r_count + CW'(1);
      else if (!w_grant && w_pop_ok) r_count <= r_count - CW'(1);
    end
  end

`ifndef FIFO_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_sel == PW'(NREQ - 1)) ? '0 : w_sel + PW'(1);
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = IDLE;
    if (bus.req_i != '0) begin
      w_state_next = w_room ? GRANT : STALL;
    end
  end

  assign bus.push_o  = r_push;
  assign bus.data_o  = r_data;
  assign bus.count_o = r_count;
  assign bus.full_o  = (r_count == CW'(DEPTH));
  assign bus.busy_o  = (r_state != IDLE);
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed plus random checks of fifo_push_arbiter against a queue-free behavioural model.
module tb_fifo_push_arbiter;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int NREQ  = 4;

  logic clk;
  logic rst;

  fifo_push_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) bus ();

  fifo_push_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: committed occupancy, next search start, last pushed word.
  int          m_count;
  int          m_ptr;
  logic        m_push;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_gnt(input logic [3:0] req);
    if (req == 4'b0 || m_count >= DEPTH) return 4'b0;
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (m_ptr + i) % NREQ;
      if (req[k]) return 4'(1 << k);
    end
    return 4'b0;
  endfunction

  function automatic logic [127:0] words(input logic [31:0] w0, input logic [31:0] w1,
                                         input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic model_reset();
    m_count = 0;
    m_ptr   = 0;
    m_push  = 1'b0;
    m_data  = 32'h0;
  endtask

  // Called at posedge+1: drive, check grant before the edge, then check registered outputs.
  task automatic step(input logic [3:0] req, input logic [127:0] data, input logic pop);
    logic [3:0] exp_g;
    int         k;
    bit         pop_ok;
    bus.req_i  = req;
    bus.data_i = data;
    bus.pop_i  = pop;
    #3;
    exp_g = model_gnt(req);
    chk("gnt_o", 32'(bus.gnt_o), 32'(exp_g));
    pop_ok = pop && (m_count > 0);
    if (exp_g != 4'b0) begin
      k = 0;
      for (int i = 0; i < NREQ; i++) if (exp_g[i]) k = i;
      m_data = data[k*WIDTH +: WIDTH];
`ifndef FIFO_ARB_FIXED_PRIO_EN
      m_ptr = (k + 1) % NREQ;
`endif
      if (!pop_ok) m_count++;
    end else if (pop_ok) begin
      m_count--;
    end
    m_push = (exp_g != 4'b0);
    @(posedge clk);
    #1;
    chk("push_o", 32'(bus.push_o), 32'(m_push));
    if (m_push) chk("data_o", bus.data_o, m_data);
    chk("count_o", 32'(bus.count_o), 32'(m_count));
    chk("full_o", 32'(bus.full_o), 32'(m_count == DEPTH));
  endtask

  initial begin
    logic [127:0] rr_data;
    rst        = 1'b1;
    bus.req_i  = '0;
    bus.data_i = '0;
    bus.pop_i  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_push_o", 32'(bus.push_o), 32'h0);
    chk("rst_data_o", bus.data_o, 32'h0);
    chk("rst_count_o", 32'(bus.count_o), 32'h0);
    chk("rst_busy_o", 32'(bus.busy_o), 32'h0);
    rst = 1'b0;

    // Round-robin burst with all four requesters.
    rr_data = words(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    for (int i = 0; i < 5; i++) step(4'b1111, rr_data, 1'b0);

    // Asynchronous reset mid-burst, requests still held.
    bus.req_i = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_push_o", 32'(bus.push_o), 32'h0);
    chk("arst_count_o", 32'(bus.count_o), 32'h0);
    chk("arst_gnt_o", 32'(bus.gnt_o), 32'h0);
    chk("arst_busy_o", 32'(bus.busy_o), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single requester fills the FIFO, then stalls.
    for (int i = 0; i < 20; i++) step(4'b0001, words(32'h100 + i, 0, 0, 0), 1'b0);
    chk("stall_busy_o", 32'(bus.busy_o), 32'h1);
    step(4'b0001, words(32'h200, 0, 0, 0), 1'b1);
    step(4'b0001, words(32'h200, 0, 0, 0), 1'b0);

    // Drain to 8, grant plus pop together, drain to empty, pop while empty.
    for (int i = 0; i < 8; i++) step(4'b0000, '0, 1'b1);
    step(4'b0001, words(32'h300, 0, 0, 0), 1'b1);
    for (int i = 0; i < 9; i++) step(4'b0000, '0, 1'b1);

    // Pointer wrap: land rr_ptr on 3, then 1001 grants 3 before 0.
    step(4'b0100, words(0, 0, 32'h402, 0), 1'b0);
    step(4'b1001, words(32'h500, 0, 0, 32'h503), 1'b0);
    step(4'b0001, words(32'h500, 0, 0, 0), 1'b0);

    // Two requesters held together.
    for (int i = 0; i < 4; i++) step(4'b0110, words(0, 32'h601, 32'h602, 0), 1'b1);

    // Random traffic with a low then high pop rate.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      logic       p;
      r = 4'($urandom_range(0, 15));
      p = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(r, words($urandom, $urandom, $urandom, $urandom), p);
    end

    step(4'b0000, '0, 1'b0);
    step(4'b0000, '0, 1'b0);
    chk("idle_busy_o", 32'(bus.busy_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
